// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and digit-packing constants for the display
//               arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int WORD_W     = DIGIT_W * NUM_DIGITS;

    // LSB of each digit field inside a packed 16-bit digit word
    localparam int DIG0_LSB = 0 * DIGIT_W;
    localparam int DIG1_LSB = 1 * DIGIT_W;
    localparam int DIG2_LSB = 2 * DIGIT_W;
    localparam int DIG3_LSB = 3 * DIGIT_W;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        S_BASE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/disp_if.sv
`default_nettype none
// ============================================================================
// Module      : disp_if
// Description : Request/ack and digit bus between display sources and the
//               display arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_if;
    import disp_pkg::*;

    word_t                base_val;
    logic                 req0;
    word_t                data0;
    logic                 ack0;
    logic                 req1;
    word_t                data1;
    logic                 ack1;
    logic                 ovl_active;
    logic [DIGIT_W-1:0]   val0;
    logic [DIGIT_W-1:0]   val1;
    logic [DIGIT_W-1:0]   val2;
    logic [DIGIT_W-1:0]   val3;

    modport master (
        output base_val, req0, data0, req1, data1,
        input  ack0, ack1, ovl_active, val0, val1, val2, val3
    );

    modport slave (
        input  base_val, req0, data0, req1, data1,
        output ack0, ack1, ovl_active, val0, val1, val2, val3
    );

endinterface
`default_nettype wire

// File: rtl/disp_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : disp_hold_timer
// Description : Overlay hold counter; flags the last cycle of a hold period.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Held at zero whenever disabled, so the count never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_expired = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp_arbiter
// Description : Shares the 4-digit display between a base source and two
//               round-robin overlay requesters with a fixed hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  wire logic clk,
    input  wire logic reset,
    disp_if.slave     bus
);

    state_t r_state;
    state_t w_state_nxt;
    word_t  r_val;
    word_t  w_val_nxt;
    word_t  r_ovl;
    word_t  w_data_sel;
    logic   r_ack0;
    logic   r_ack1;
    logic   r_last;
    logic   w_elig0;
    logic   w_elig1;
    logic   w_sel;
    logic   w_grant;
    logic   w_expired;
    logic   w_hold;

    // A requester is never eligible in its own ack cycle
    assign w_elig0    = bus.req0 & ~r_ack0;
    assign w_elig1    = bus.req1 & ~r_ack1;
    assign w_sel      = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
    assign w_data_sel = w_sel ? bus.data1 : bus.data0;
    assign w_hold     = (r_state == S_HOLD);

    disp_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_grant | w_expired),
        .i_enable  (w_hold),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_BASE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_grant     = 1'b0;
        w_state_nxt = r_state;
        w_val_nxt   = bus.base_val;
        case (r_state)
            S_BASE: begin
                w_grant = w_elig0 | w_elig1;
            end
            S_HOLD: begin
                if (w_expired) begin
                    w_grant = w_elig0 | w_elig1;
                    if (!w_grant) begin
                        w_state_nxt = S_BASE;
                    end
                end else begin
                    // Retrigger only by the owner, and only when the other side is idle
                    w_grant = r_last ? (w_elig1 & ~w_elig0) : (w_elig0 & ~w_elig1);
                end
            end
            default: begin
                w_state_nxt = S_BASE;
            end
        endcase

        if (w_grant) begin
            w_state_nxt = S_HOLD;
            w_val_nxt   = w_data_sel;
        end else if (w_state_nxt == S_HOLD) begin
            w_val_nxt   = r_ovl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val  <= '0;
            r_ovl  <= '0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_last <= 1'b1;
        end else begin
            r_val  <= w_val_nxt;
            r_ack0 <= w_grant & ~w_sel;
            r_ack1 <= w_grant &  w_sel;
            if (w_grant) begin
                r_ovl  <= w_data_sel;
                r_last <= w_sel;
            end
        end
    end

    assign bus.val0       = r_val[DIG0_LSB +: DIGIT_W];
    assign bus.val1       = r_val[DIG1_LSB +: DIGIT_W];
    assign bus.val2       = r_val[DIG2_LSB +: DIGIT_W];
    assign bus.val3       = r_val[DIG3_LSB +: DIGIT_W];
    assign bus.ack0       = r_ack0;
    assign bus.ack1       = r_ack1;
    assign bus.ovl_active = w_hold;

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_arbiter
// Description : Scoreboard bench for disp_arbiter against a hold-countdown
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_arbiter;
    import disp_pkg::*;

    localparam int c_HOLD = 8;

    logic clk = 1'b0;
    logic reset;

    disp_if bus ();

    disp_arbiter #(
        .HOLD_CYCLES (c_HOLD),
        .CNT_W       (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        ovl;
        logic        a0;
        logic        a1;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the display and how many cycles remain
    int          m_owner;
    int          m_remaining;
    bit          m_last;
    logic [15:0] m_ovl;
    bit          m_a0;
    bit          m_a1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner     = -1;
        m_remaining = 0;
        m_last      = 1'b1;
        m_ovl       = 16'h0;
        m_a0        = 1'b0;
        m_a1        = 1'b0;
    endfunction

    function automatic void model_step();
        bit   e0, e1, grant;
        int   win;
        exp_t t;
        e0    = bus.req0 && !m_a0;
        e1    = bus.req1 && !m_a1;
        grant = 1'b0;
        win   = (e0 && e1) ? (m_last ? 0 : 1) : (e1 ? 1 : 0);
        if (m_owner < 0) begin
            grant = e0 || e1;
        end else begin
            m_remaining--;
            if (m_remaining == 0) begin
                grant = e0 || e1;
                if (!grant) m_owner = -1;
            end else if (m_owner == 0) begin
                grant = e0 && !e1;
            end else begin
                grant = e1 && !e0;
            end
        end
        if (grant) begin
            m_owner     = win;
            m_remaining = c_HOLD;
            m_last      = (win == 1);
            m_ovl       = (win == 1) ? bus.data1 : bus.data0;
        end
        m_a0  = grant && (win == 0);
        m_a1  = grant && (win == 1);
        t.val = (m_owner < 0) ? bus.base_val : m_ovl;
        t.ovl = (m_owner >= 0);
        t.a0  = m_a0;
        t.a1  = m_a1;
        exp_q.push_back(t);
    endfunction

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("val", {bus.val3, bus.val2, bus.val1, bus.val0}, mon_e.val);
            check("ovl_active", {15'd0, bus.ovl_active}, {15'd0, mon_e.ovl});
            check("ack0", {15'd0, bus.ack0}, {15'd0, mon_e.a0});
            check("ack1", {15'd0, bus.ack1}, {15'd0, mon_e.a1});
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic request(input int n, input logic [15:0] d, input int extra);
        int   waited;
        logic got;
        waited = 0;
        got    = 1'b0;
        if (n == 0) begin bus.data0 = d; bus.req0 = 1'b1; end
        else        begin bus.data1 = d; bus.req1 = 1'b1; end
        while (!got && waited < 64) begin
            cycles(1);
            waited++;
            got = (n == 0) ? bus.ack0 : bus.ack1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout req%0d: no ack after %0d cycles, expected ack", n, waited);
        end
        cycles(extra);
        if (n == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    // Asserts reset mid-cycle and checks the outputs clear without a clock edge
    task automatic apply_reset();
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check("rst_val", {bus.val3, bus.val2, bus.val1, bus.val0}, 16'h0000);
        check("rst_ovl", {15'd0, bus.ovl_active}, 16'h0000);
        check("rst_acks", {14'd0, bus.ack1, bus.ack0}, 16'h0000);
        @(posedge clk);
        #2;
        cycles(1);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.base_val = 16'h0000;
        bus.req0     = 1'b0;
        bus.req1     = 1'b0;
        bus.data0    = 16'h0000;
        bus.data1    = 16'h0000;
        model_reset();
        cycles(2);
        check("init_val", {bus.val3, bus.val2, bus.val1, bus.val0}, 16'h0000);
        check("init_ovl", {15'd0, bus.ovl_active}, 16'h0000);
        check("init_acks", {14'd0, bus.ack1, bus.ack0}, 16'h0000);
        reset = 1'b0;

        // Base pass-through
        bus.base_val = 16'h1234;
        cycles(3);
        check("base_direct", {bus.val3, bus.val2, bus.val1, bus.val0}, 16'h1234);

        // Single overlay, full hold then back to base
        request(0, 16'hA5C0, 0);
        cycles(12);

        // Simultaneous requests from reset, then repeated
        apply_reset();
        fork
            request(0, 16'hB0B0, 0);
            request(1, 16'hC1C1, 0);
        join
        cycles(12);
        fork
            request(0, 16'hB2B2, 0);
            request(1, 16'hC3C3, 0);
        join
        cycles(20);

        // Owner retrigger with the other side idle
        request(0, 16'hA5C0, 0);
        cycles(4);
        request(0, 16'h7777, 0);
        cycles(12);

        // Retrigger blocked by a pending other requester
        request(0, 16'h1111, 0);
        cycles(2);
        fork
            request(1, 16'h2222, 0);
            begin
                cycles(1);
                request(0, 16'h3333, 0);
            end
        join
        cycles(12);

        // Reset mid-hold, then a request held across reset
        request(0, 16'h4444, 0);
        cycles(3);
        apply_reset();
        cycles(3);
        check("post_rst_base", {bus.val3, bus.val2, bus.val1, bus.val0}, 16'h1234);
        bus.data1 = 16'h9999;
        bus.req1  = 1'b1;
        cycles(2);
        apply_reset();
        request(1, 16'h9999, 0);
        cycles(12);

        // Randomized traffic
        fork
            for (int i = 0; i < 25; i++) begin
                cycles(int'($urandom_range(0, 12)));
                request(0, 16'($urandom), int'($urandom_range(0, 3)));
            end
            for (int j = 0; j < 25; j++) begin
                cycles(int'($urandom_range(0, 12)));
                request(1, 16'($urandom), int'($urandom_range(0, 3)));
            end
            for (int k = 0; k < 500; k++) begin
                if ($urandom_range(0, 3) == 0) bus.base_val = 16'($urandom);
                cycles(1);
            end
        join
        cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
